mem_access_stage: RTL

- MIPS pipeline MEM stage; consumes the EX/MEM register outputs.
- Resolves branch/jump PC selection and performs data-memory load/store over a req/ack handshake, so memory may take one or many cycles.
- Stalls upstream stages while an access is outstanding.
- Holds the MEM/WB pipeline register, which feeds writeback.

---
 rtl/mem_access_stage_pkg.sv | 7 +
 rtl/mem_access_stage_if.sv | 11 +
 rtl/mem_access_stage_mem_wb_reg.sv | 30 +++
 rtl/mem_access_stage.sv | 91 +++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// mips_mem_pkg: shared types and constants for the MIPS MEM stage.
package mips_mem_pkg;
    typedef enum logic {IDLE, BUSY} state_t;
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    localparam logic [1:0] WB_BUBBLE = 2'b00;
endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: data-memory req/ack bus between the MEM stage and memory.
interface mem_access_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    modport master(output req, we, addr, wdata, input rdata, ack);
    modport slave(input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_access_stage_mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register with sync active-low clear and bubble insert.
module mem_wb_reg
    import mips_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_bubble,
    input  logic [1:0]  i_wb,
    input  logic [31:0] i_read_data,
    input  logic [31:0] i_alu_result,
    input  logic [4:0]  i_insaddr,
    output logic [1:0]  o_wb,
    output logic [31:0] o_read_data,
    output logic [31:0] o_alu_result,
    output logic [4:0]  o_insaddr
);
    always_ff @(posedge clk) begin
        if (!reset || i_bubble) begin
            o_wb         <= WB_BUBBLE;
            o_read_data  <= '0;
            o_alu_result <= '0;
            o_insaddr    <= '0;
        end else begin
            o_wb         <= i_wb;
            o_read_data  <= i_read_data;
            o_alu_result <= i_alu_result;
            o_insaddr    <= i_insaddr;
        end
    end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS MEM stage; PC select, req/ack data-memory access with
// timeout, upstream stall and the MEM/WB register.
module mem_access_stage
    import mips_mem_pkg::*;
#(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = $clog2(WAIT_LIMIT + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          i_wb,
    input  logic                i_jump,
    input  logic                i_branch,
    input  logic                i_mem_read,
    input  logic                i_mem_write,
    input  logic                i_zero,
    input  logic [31:0]         i_alu_result,
    input  logic [31:0]         i_b,
    input  logic [4:0]          i_insaddr,
    input  logic [31:0]         i_next_address,
    input  logic [31:0]         i_jaddr,
    output logic                o_pcsrc,
    output logic                o_jump,
    output logic [31:0]         o_branch_target,
    output logic [31:0]         o_jump_target,
    output logic                o_stall,
    output logic                o_mem_err,
    output logic [1:0]          o_wb,
    output logic [31:0]         o_read_data,
    output logic [31:0]         o_alu_result,
    output logic [4:0]          o_insaddr,
    mem_access_stage_if.master  dmem
);
    state_t           r_state, w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mem_err;
    logic             w_op, w_busy, w_timeout, w_bubble;
    logic [31:0]      w_read_data;

    assign w_op      = i_mem_read | i_mem_write;
    assign w_busy    = r_state == BUSY;
    assign w_timeout = w_busy & ~dmem.ack & (r_cnt == CNT_W'(WAIT_LIMIT - 1));
    assign w_bubble  = o_stall | w_timeout;
    // a simultaneous read+write is treated as a write, so no read data retires
    assign w_read_data = (i_mem_read & ~i_mem_write) ? dmem.rdata : '0;

    assign o_pcsrc         = i_branch & i_zero;
    assign o_jump          = i_jump;
    assign o_branch_target = i_next_address;
    assign o_jump_target   = i_jaddr;
    assign o_mem_err       = r_mem_err;
    assign dmem.we         = i_mem_write;
    assign dmem.addr       = i_alu_result;
    assign dmem.wdata      = i_b;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_busy ? r_cnt + CNT_W'(1) : '0;
            r_mem_err <= r_mem_err | w_timeout;
        end
    end

    always_comb begin
        w_next_state = w_busy ? ((dmem.ack | w_timeout) ? IDLE : BUSY)
                              : ((w_op & ~dmem.ack) ? BUSY : IDLE);
    end

    always_comb begin
        dmem.req = reset & (w_busy | w_op);
        o_stall  = reset & ~dmem.ack & (w_busy ? ~w_timeout : w_op);
    end

    mem_wb_reg u_mem_wb_reg (
        .clk         (clk),
        .reset       (reset),
        .i_bubble    (w_bubble),
        .i_wb        (i_wb),
        .i_read_data (w_read_data),
        .i_alu_result(i_alu_result),
        .i_insaddr   (i_insaddr),
        .o_wb        (o_wb),
        .o_read_data (o_read_data),
        .o_alu_result(o_alu_result),
        .o_insaddr   (o_insaddr)
    );
endmodule
